// File: rtl/gpio_chk_pkg.sv
// rtl/gpio_chk_pkg.sv - shared constants, state and error-code types for the GPIO sweep checker
package gpio_chk_pkg;

    localparam int NUM_PINS      = 34;
    localparam int CYCLES_PER_MS = 10000;

    localparam logic [5:0] NO_PIN   = 6'd63;
    localparam logic [5:0] LAST_PIN = 6'(NUM_PINS - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        TRACK      = 2'd2,
        ERROR      = 2'd3
    } chk_state_t;

    typedef enum logic [2:0] {
        ERR_NONE  = 3'd0,
        ERR_MULTI = 3'd1,
        ERR_ORDER = 3'd2,
        ERR_SHORT = 3'd3,
        ERR_LONG  = 3'd4,
        ERR_GAP   = 3'd5
    } err_code_t;

    // Lower dwell bound clamps at zero so tiny expected values never wrap around.
    function automatic logic [27:0] dwell_lower(input logic [27:0] expected,
                                                input logic [27:0] tol);
        return (expected < tol) ? 28'd0 : expected - tol;
    endfunction

endpackage

// File: rtl/onehot_encoder_34.sv
// rtl/onehot_encoder_34.sv - classifies a 34-bit pin pattern and encodes a single high pin to its index
module onehot_encoder_34
    import gpio_chk_pkg::*;
(
    input  logic [NUM_PINS-1:0] in,
    output logic [5:0]          idx,
    output logic                one_hot,
    output logic                all_zero,
    output logic                multi_hot
);

    // OR of set-bit indices; only meaningful when exactly one bit is set.
    always_comb begin
        idx = 6'd0;
        for (int i = 0; i < NUM_PINS; i++) begin
            if (in[i]) begin
                idx = idx | 6'(i);
            end
        end
    end

    assign all_zero  = (in == '0);
    assign one_hot   = !all_zero && ((in & (in - 34'd1)) == '0);
    assign multi_hot = !all_zero && !one_hot;

endmodule

// File: rtl/gpio_sequence_checker.sv
// rtl/gpio_sequence_checker.sv - checks pin order and per-pin dwell of a walking-one GPIO sweep
module gpio_sequence_checker
    import gpio_chk_pkg::*;
#(
    parameter int TOL_CYCLES    = 16,
    parameter int STABLE_CYCLES = 4,
    parameter int MS_CYCLES     = CYCLES_PER_MS
)(
    input  logic                clk,
    input  logic                nrst,
    input  logic                enable,
    input  logic                clear,
    input  logic [13:0]         prescaler,
    input  logic [NUM_PINS-1:0] gpio_in,
    output logic                done,
    output logic                error,
    output logic [2:0]          err_code,
    output logic [5:0]          cur_pin,
    output logic [7:0]          sweep_count
);

    localparam int RW = $clog2(STABLE_CYCLES + 1);

    logic [NUM_PINS-1:0] sync1, sync2, sync2_d, acc_pat;
    logic [RW-1:0]       run_q, run_now;
    logic                evt;
    logic [5:0]          ev_idx;
    logic                ev_one, ev_zero, ev_multi;
    logic [27:0]         expected, lo_bound, hi_bound;
    logic [27:0]         dwell, dwell_inc;
    chk_state_t          state;
    err_code_t           err_q, fault;

    onehot_encoder_34 u_enc (
        .in        (sync2),
        .idx       (ev_idx),
        .one_hot   (ev_one),
        .all_zero  (ev_zero),
        .multi_hot (ev_multi)
    );

    // run_now counts consecutive identical synced samples including the current one.
    always_comb begin
        run_now = RW'(1);
        if (sync2 == sync2_d) begin
            run_now = (run_q >= RW'(STABLE_CYCLES)) ? RW'(STABLE_CYCLES) : run_q + RW'(1);
        end
    end

    assign evt = (run_now == RW'(STABLE_CYCLES)) && (sync2 != acc_pat);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1   <= '0;
            sync2   <= '0;
            sync2_d <= '0;
            run_q   <= '0;
            acc_pat <= '0;
        end else if (clear) begin
            sync1   <= '0;
            sync2   <= '0;
            sync2_d <= '0;
            run_q   <= '0;
            acc_pat <= '0;
        end else begin
            sync1   <= gpio_in;
            sync2   <= sync1;
            sync2_d <= sync2;
            run_q   <= run_now;
            if (evt) begin
                acc_pat <= sync2;
            end
        end
    end

    assign expected  = {14'd0, prescaler} * 28'(MS_CYCLES);
    assign lo_bound  = dwell_lower(expected, 28'(TOL_CYCLES));
    assign hi_bound  = expected + 28'(TOL_CYCLES);
    assign dwell_inc = (dwell == '1) ? dwell : dwell + 28'd1;

    // Error detection; the order of the checks sets the cause priority.
    always_comb begin
        fault = ERR_NONE;
        if (enable && state == WAIT_FIRST && evt && ev_multi) begin
            fault = ERR_MULTI;
        end else if (enable && state == TRACK) begin
            if (evt) begin
                if (ev_multi) begin
                    fault = ERR_MULTI;
                end else if (dwell < lo_bound) begin
                    fault = ERR_SHORT;
                end else if (ev_one && ev_idx == cur_pin + 6'd1) begin
                    fault = ERR_NONE;
                end else if (cur_pin == LAST_PIN && (ev_zero || (ev_one && ev_idx == 6'd0))) begin
                    fault = ERR_NONE;
                end else if (ev_zero) begin
                    fault = ERR_GAP;
                end else begin
                    fault = ERR_ORDER;
                end
            end else if (dwell_inc > hi_bound) begin
                fault = ERR_LONG;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            err_q       <= ERR_NONE;
            error       <= 1'b0;
            done        <= 1'b0;
            cur_pin     <= NO_PIN;
            sweep_count <= 8'd0;
            dwell       <= 28'd0;
        end else begin
            done <= 1'b0;
            if (clear) begin
                state       <= IDLE;
                err_q       <= ERR_NONE;
                error       <= 1'b0;
                cur_pin     <= NO_PIN;
                sweep_count <= 8'd0;
                dwell       <= 28'd0;
            end else if (fault != ERR_NONE) begin
                state <= ERROR;
                error <= 1'b1;
                err_q <= fault;
            end else begin
                case (state)
                    IDLE: begin
                        dwell <= 28'd0;
                        if (enable && prescaler != 14'd0) begin
                            state <= WAIT_FIRST;
                        end
                    end
                    WAIT_FIRST: begin
                        if (!enable) begin
                            state   <= IDLE;
                            cur_pin <= NO_PIN;
                        end else if (evt && ev_one && ev_idx == 6'd0) begin
                            state   <= TRACK;
                            cur_pin <= 6'd0;
                            dwell   <= 28'd1;
                        end
                    end
                    TRACK: begin
                        if (!enable) begin
                            state   <= IDLE;
                            cur_pin <= NO_PIN;
                        end else if (evt) begin
                            // No fault on a change means either the next pin or the end-of-sweep wrap.
                            if (cur_pin == LAST_PIN) begin
                                done <= 1'b1;
                                if (sweep_count != 8'hFF) begin
                                    sweep_count <= sweep_count + 8'd1;
                                end
                                if (ev_zero) begin
                                    state <= WAIT_FIRST;
                                    dwell <= 28'd0;
                                end else begin
                                    cur_pin <= 6'd0;
                                    dwell   <= 28'd1;
                                end
                            end else begin
                                cur_pin <= cur_pin + 6'd1;
                                dwell   <= 28'd1;
                            end
                        end else begin
                            dwell <= dwell_inc;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign err_code = err_q;

endmodule
